// File: rtl/riscv_pkg.sv
// Shared fetch-stage types and constants.
// Contents: XLEN, NOP_INSTR, RESET_PC_DEFAULT, fetch_entry_t {pc, instr},
//           sat_inc32 helper for saturating event counters.
package riscv_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = XLEN'(32'h0000_0000);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
    } fetch_entry_t;

    // Increment by one when en is set, sticking at all-ones.
    function automatic logic [31:0] sat_inc32(input logic [31:0] v, input logic en);
        return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response channel.
// master: fetch side (drives request, receives response).
// slave : memory side.
// Signals: imem_req_valid/ready/addr (request), imem_rsp_valid/data (in-order response).
interface fetch_unit_if;
    import riscv_pkg::*;

    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [31:0]     imem_rsp_data;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data
    );

endinterface

// File: rtl/fetch_fifo.sv
// Power-of-two circular FIFO used for the prefetch queue and the PC tag FIFO.
// Ports: clk, reset (sync, active-high), push/push_data, pop, clear,
//        head (combinational view of oldest entry), count, full, empty.
// Callers never push when full unless popping in the same cycle, and never pop when empty.
module fetch_fifo
    import riscv_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter type T = fetch_entry_t
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  T                       push_data,
    input  logic                   pop,
    input  logic                   clear,
    output T                       head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    T               mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;

    // Pointers and occupancy; clear wins over push/pop.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Storage carries no reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (push && !clear) mem[wr_ptr] <= push_data;
    end

    always_comb begin
        head  = mem[rd_ptr];
        full  = (count == CW'(DEPTH));
        empty = (count == '0);
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage with prefetch queue feeding the IF/ID register.
// Ports: clk, reset (sync, active-high); imem (fetch_unit_if.master);
//        StallD, FlushD, PCSrcE, PCTargetE from hazard/EX;
//        InstrD, PCD, PCPlus4D, ValidD to decode.
// Optional: FETCH_PERF_EN adds perf_fetched, perf_discarded, perf_empty_cycles.
// imem_req_valid is combinational (depends on PCSrcE and credit); all D outputs registered.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    fetch_unit_if.master      imem,
    input  logic              StallD,
    input  logic              FlushD,
    input  logic              PCSrcE,
    input  logic [XLEN-1:0]   PCTargetE,
    output logic [31:0]       InstrD,
    output logic [XLEN-1:0]   PCD,
    output logic [XLEN-1:0]   PCPlus4D,
    output logic              ValidD
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]       perf_fetched,
    output logic [31:0]       perf_discarded,
    output logic [31:0]       perf_empty_cycles
`endif
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [XLEN-1:0] pc;
    logic [CW-1:0]   discard;
    logic [CW-1:0]   q_count;
    logic [CW-1:0]   tag_count;
    logic            q_full, q_empty, tag_full, tag_empty;
    logic            unused_flags;
    fetch_entry_t    q_head, q_in;
    logic [XLEN-1:0] tag_head;
    logic            accept, drop, push, pop, credit_ok;

    // Tag FIFO occupancy doubles as the in-flight request count.
    always_comb begin
        credit_ok = ((CW+1)'(q_count) + (CW+1)'(tag_count)) < (CW+1)'(DEPTH);
        imem.imem_req_valid = !reset && !PCSrcE && credit_ok;
        imem.imem_req_addr  = pc;
        accept = imem.imem_req_valid && imem.imem_req_ready;
        drop   = imem.imem_rsp_valid && (PCSrcE || (discard != '0));
        push   = imem.imem_rsp_valid && !drop;
        pop    = !reset && !FlushD && !StallD && !PCSrcE && !q_empty;
        q_in   = '{pc: tag_head, instr: imem.imem_rsp_data};
    end

    assign unused_flags = ^{q_full, tag_full, tag_empty};

    fetch_fifo #(.DEPTH(DEPTH), .T(fetch_entry_t)) u_queue (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (q_in),
        .pop       (pop),
        .clear     (PCSrcE),
        .head      (q_head),
        .count     (q_count),
        .full      (q_full),
        .empty     (q_empty)
    );

    // Never cleared: stale responses still arrive and must consume their tags.
    fetch_fifo #(.DEPTH(DEPTH), .T(logic [XLEN-1:0])) u_tags (
        .clk       (clk),
        .reset     (reset),
        .push      (accept),
        .push_data (pc),
        .pop       (imem.imem_rsp_valid),
        .clear     (1'b0),
        .head      (tag_head),
        .count     (tag_count),
        .full      (tag_full),
        .empty     (tag_empty)
    );

    // PC and drop counter; a redirect marks every outstanding response stale.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc      <= RESET_PC;
            discard <= '0;
        end else if (PCSrcE) begin
            pc      <= {PCTargetE[XLEN-1:2], 2'b00};
            discard <= tag_count - CW'(imem.imem_rsp_valid);
        end else begin
            if (accept) pc <= pc + XLEN'(4);
            if (imem.imem_rsp_valid && (discard != '0)) discard <= discard - CW'(1);
        end
    end

    // IF/ID register: flush beats stall; redirect holds unless flushed.
    always_ff @(posedge clk) begin
        if (reset || FlushD) begin
            InstrD   <= NOP_INSTR;
            PCD      <= '0;
            PCPlus4D <= '0;
            ValidD   <= 1'b0;
        end else if (StallD || PCSrcE) begin
            InstrD   <= InstrD;
        end else if (!q_empty) begin
            InstrD   <= q_head.instr;
            PCD      <= q_head.pc;
            PCPlus4D <= q_head.pc + XLEN'(4);
            ValidD   <= 1'b1;
        end else begin
            InstrD   <= NOP_INSTR;
            PCD      <= '0;
            PCPlus4D <= '0;
            ValidD   <= 1'b0;
        end
    end

`ifdef FETCH_PERF_EN
    // Saturating event counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetched      <= '0;
            perf_discarded    <= '0;
            perf_empty_cycles <= '0;
        end else begin
            perf_fetched      <= sat_inc32(perf_fetched, push);
            perf_discarded    <= sat_inc32(perf_discarded, drop);
            perf_empty_cycles <= sat_inc32(perf_empty_cycles,
                                           !FlushD && !StallD && !PCSrcE && q_empty);
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: one table row per clock, plus reset sequences.
module tb_fetch_unit;
    import riscv_pkg::*;

    logic        clk;
    logic        reset;
    logic        StallD, FlushD, PCSrcE;
    logic [31:0] PCTargetE;
    logic [31:0] InstrD, PCD, PCPlus4D;
    logic        ValidD;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched, perf_discarded, perf_empty_cycles;
`endif

    fetch_unit_if imem ();

    fetch_unit #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clk       (clk),
        .reset     (reset),
        .imem      (imem),
        .StallD    (StallD),
        .FlushD    (FlushD),
        .PCSrcE    (PCSrcE),
        .PCTargetE (PCTargetE),
        .InstrD    (InstrD),
        .PCD       (PCD),
        .PCPlus4D  (PCPlus4D),
        .ValidD    (ValidD)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched      (perf_fetched),
        .perf_discarded    (perf_discarded),
        .perf_empty_cycles (perf_empty_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        stall, flush, pcsrc;
        logic [31:0] target;
        logic        ready, hold;
        logic        rv;     // expected imem_req_valid before the edge
        logic [31:0] addr;   // expected imem_req_addr before the edge
        logic        vd;     // expected ValidD after the edge
        logic [31:0] pcd;    // expected PCD after the edge (when vd)
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] pend[$];
    int          n_cmp = 0;
    int          n_bad = 0;

    function automatic logic [31:0] memword(input logic [31:0] a);
        return 32'hCAFE_0000 + a;
    endfunction

    function automatic vec_t mk(input logic s, input logic f, input logic p, input logic [31:0] t,
                                input logic r, input logic h, input logic rv, input logic [31:0] a,
                                input logic vd, input logic [31:0] pcd);
        vec_t v;
        v.stall = s; v.flush = f; v.pcsrc = p; v.target = t; v.ready = r; v.hold = h;
        v.rv = rv; v.addr = a; v.vd = vd; v.pcd = pcd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    initial begin
        reset = 1'b1;
        StallD = 1'b0; FlushD = 1'b0; PCSrcE = 1'b0; PCTargetE = '0;
        imem.imem_req_ready = 1'b0;
        imem.imem_rsp_valid = 1'b0;
        imem.imem_rsp_data  = '0;

        //          st fl pc target      rd hd  rv addr          vd pcd
        vecs.push_back(mk(0,0,0,32'h0,   1,0, 1,32'h000, 0,32'h000)); // 0 first accept
        vecs.push_back(mk(0,0,0,32'h0,   1,0, 1,32'h004, 0,32'h000));
        vecs.push_back(mk(0,0,0,32'h0,   1,0, 1,32'h008, 1,32'h000)); // 2 cycles after accept
        vecs.push_back(mk(0,0,0,32'h0,   1,0, 1,32'h00C, 1,32'h004));
        vecs.push_back(mk(0,0,0,32'h0,   0,0, 1,32'h010, 1,32'h008)); // 4 ready low x5
        vecs.push_back(mk(0,0,0,32'h0,   0,0, 1,32'h010, 1,32'h00C));
        vecs.push_back(mk(0,0,0,32'h0,   0,0, 1,32'h010, 0,32'h000));
        vecs.push_back(mk(0,0,0,32'h0,   0,0, 1,32'h010, 0,32'h000));
        vecs.push_back(mk(0,0,0,32'h0,   0,0, 1,32'h010, 0,32'h000));
        vecs.push_back(mk(1,0,0,32'h0,   1,0, 1,32'h010, 0,32'h000)); // 9 stall x6
        vecs.push_back(mk(1,0,0,32'h0,   1,0, 1,32'h014, 0,32'h000));
        vecs.push_back(mk(1,0,0,32'h0,   1,0, 1,32'h018, 0,32'h000));
        vecs.push_back(mk(1,0,0,32'h0,   1,0, 1,32'h01C, 0,32'h000));
        vecs.push_back(mk(1,0,0,32'h0,   1,0, 0,32'h020, 0,32'h000)); // credit exhausted
        vecs.push_back(mk(1,0,0,32'h0,   1,0, 0,32'h020, 0,32'h000));
        vecs.push_back(mk(0,0,0,32'h0,   1,0, 0,32'h020, 1,32'h010)); // 15 release
        vecs.push_back(mk(0,0,0,32'h0,   1,0, 1,32'h020, 1,32'h014));
        vecs.push_back(mk(0,0,0,32'h0,   1,0, 1,32'h024, 1,32'h018));
        vecs.push_back(mk(0,0,0,32'h0,   1,0, 1,32'h028, 1,32'h01C));
        vecs.push_back(mk(0,0,0,32'h0,   1,0, 1,32'h02C, 1,32'h020));
        vecs.push_back(mk(0,0,0,32'h0,   1,1, 1,32'h030, 1,32'h024)); // 20 memory holds
        vecs.push_back(mk(0,0,0,32'h0,   1,1, 1,32'h034, 1,32'h028));
        vecs.push_back(mk(0,1,1,32'h101, 1,1, 0,32'h038, 0,32'h000)); // 22 redirect, 3 in flight
        vecs.push_back(mk(0,0,0,32'h0,   1,0, 1,32'h100, 0,32'h000));
        vecs.push_back(mk(0,0,0,32'h0,   1,0, 1,32'h104, 0,32'h000));
        vecs.push_back(mk(0,0,0,32'h0,   1,0, 1,32'h108, 0,32'h000));
        vecs.push_back(mk(0,0,0,32'h0,   1,0, 1,32'h10C, 0,32'h000));
        vecs.push_back(mk(0,0,0,32'h0,   1,0, 0,32'h110, 1,32'h100)); // 27 first post-redirect
        vecs.push_back(mk(0,0,0,32'h0,   1,0, 1,32'h110, 1,32'h104));
        vecs.push_back(mk(0,0,0,32'h0,   1,0, 1,32'h114, 1,32'h108));
        vecs.push_back(mk(0,1,1,32'h200, 1,0, 0,32'h118, 0,32'h000)); // 30 redirect + response
        vecs.push_back(mk(0,0,0,32'h0,   1,0, 1,32'h200, 0,32'h000));
        vecs.push_back(mk(0,0,0,32'h0,   1,0, 1,32'h204, 0,32'h000));
        vecs.push_back(mk(0,0,0,32'h0,   1,0, 1,32'h208, 1,32'h200));
        vecs.push_back(mk(1,1,0,32'h0,   1,0, 1,32'h20C, 0,32'h000)); // 34 flush over stall
        vecs.push_back(mk(0,0,0,32'h0,   1,0, 1,32'h210, 1,32'h204)); // 204 was not popped
        vecs.push_back(mk(0,0,0,32'h0,   1,0, 1,32'h214, 1,32'h208));

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset InstrD", InstrD, NOP_INSTR);
        chk("reset PCD", PCD, 32'h0);
        chk("reset PCPlus4D", PCPlus4D, 32'h0);
        chk("reset ValidD", 32'(ValidD), 32'h0);
        chk("reset req_valid", 32'(imem.imem_req_valid), 32'h0);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            vec_t        v;
            logic        rv;
            logic [31:0] addr;
            v = vecs[i];
            StallD = v.stall; FlushD = v.flush; PCSrcE = v.pcsrc; PCTargetE = v.target;
            imem.imem_req_ready = v.ready;
            if (!v.hold && (pend.size() > 0)) begin
                imem.imem_rsp_valid = 1'b1;
                imem.imem_rsp_data  = memword(pend.pop_front());
            end else begin
                imem.imem_rsp_valid = 1'b0;
                imem.imem_rsp_data  = 32'hDEAD_BEEF;
            end
            #1;
            rv   = imem.imem_req_valid;
            addr = imem.imem_req_addr;
            chk($sformatf("row%0d req_valid", i), 32'(rv), 32'(v.rv));
            chk($sformatf("row%0d req_addr", i), addr, v.addr);
            if (rv && v.ready) pend.push_back(addr);
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("row%0d ValidD", i), 32'(ValidD), 32'(v.vd));
            chk($sformatf("row%0d InstrD", i), InstrD, v.vd ? memword(v.pcd) : NOP_INSTR);
            if (v.vd) begin
                chk($sformatf("row%0d PCD", i), PCD, v.pcd);
                chk($sformatf("row%0d PCPlus4D", i), PCPlus4D, v.pcd + 32'd4);
            end
        end

`ifdef FETCH_PERF_EN
        chk("perf_discarded", perf_discarded, 32'd5);
`endif

        // Reset mid-operation with responses outstanding.
        StallD = 1'b0; FlushD = 1'b0; PCSrcE = 1'b0;
        imem.imem_rsp_valid = 1'b0;
        reset = 1'b1;
        #1;
        chk("midreset req_valid", 32'(imem.imem_req_valid), 32'h0);
        @(posedge clk);
        @(negedge clk);
        chk("midreset InstrD", InstrD, NOP_INSTR);
        chk("midreset PCD", PCD, 32'h0);
        chk("midreset PCPlus4D", PCPlus4D, 32'h0);
        chk("midreset ValidD", 32'(ValidD), 32'h0);
`ifdef FETCH_PERF_EN
        chk("midreset perf_discarded", perf_discarded, 32'h0);
        chk("midreset perf_fetched", perf_fetched, 32'h0);
`endif
        pend.delete();
        reset = 1'b0;
        imem.imem_req_ready = 1'b0;
        #1;
        chk("post-reset req_valid", 32'(imem.imem_req_valid), 32'h1);
        chk("post-reset req_addr", imem.imem_req_addr, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
